// File: rtl/word_serializer_pkg.sv
// ============================================================================
// serializer_pkg : shared state type and limits for word_serializer
// Rev 1.0
// ============================================================================
`default_nettype none

package serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam int C_SER_MAX_WIDTH = 32;

endpackage

`default_nettype wire

// File: rtl/word_serializer_if.sv
// ============================================================================
// word_serializer_if : word handshake in, serial bit stream out
// Rev 1.0
// ============================================================================
`default_nettype none

interface word_serializer_if #(
  parameter int WIDTH = 8
);

  logic             word_valid;
  logic [WIDTH-1:0] word_data;
  logic             word_ready;
  logic             new_bit;
  logic             bit_valid;
  logic             last_bit;

  modport master (
    output word_valid, word_data,
    input  word_ready, new_bit, bit_valid, last_bit
  );

  modport slave (
    input  word_valid, word_data,
    output word_ready, new_bit, bit_valid, last_bit
  );

endinterface

`default_nettype wire

// File: rtl/word_serializer.sv
// ============================================================================
// word_serializer : valid/ready word in, one registered bit per clock out
// Rev 1.0
// ============================================================================
`default_nettype none

module word_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  word_serializer_if.slave    bus
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  ser_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             new_bit_q, new_bit_d;
  logic             bit_valid_q, bit_valid_d;
  logic             last_bit_q, last_bit_d;
  logic             ready;
  logic             accept;

  assign ready  = !rst && ((state_q == IDLE) || (cnt_q == LAST_CNT));
  assign accept = bus.word_valid && ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shreg_d = bus.word_data;
        end
      end
      SHIFT: begin
        if (cnt_q != LAST_CNT) begin
          cnt_d   = cnt_q + CNT_W'(1);
          shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
        end else if (accept) begin
          cnt_d   = '0;
          shreg_d = bus.word_data;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered copies of the next cycle's head bit and flags.
    new_bit_d   = IDLE_BIT;
    bit_valid_d = 1'b0;
    last_bit_d  = 1'b0;
    if (state_d == SHIFT) begin
      new_bit_d   = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
      bit_valid_d = 1'b1;
      last_bit_d  = (cnt_d == LAST_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      new_bit_q   <= IDLE_BIT;
      bit_valid_q <= 1'b0;
      last_bit_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      new_bit_q   <= new_bit_d;
      bit_valid_q <= bit_valid_d;
      last_bit_q  <= last_bit_d;
    end
  end

  assign bus.word_ready = ready;
  assign bus.new_bit    = new_bit_q;
  assign bus.bit_valid  = bit_valid_q;
  assign bus.last_bit   = last_bit_q;

endmodule

`default_nettype wire

// File: tb/tb_word_serializer.sv
// ============================================================================
// tb_word_serializer : three serializer configurations against a bit-queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_word_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // dut0: W=8 MSB-first idle 0; dut1: W=4 LSB-first idle 1; dut2: W=1 idle 0
  word_serializer_if #(.WIDTH(8)) bus0 ();
  word_serializer_if #(.WIDTH(4)) bus1 ();
  word_serializer_if #(.WIDTH(1)) bus2 ();

  word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  word_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  word_serializer #(.WIDTH(1), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  logic [2:0]  vld = '0;
  logic [31:0] dat [3];
  logic [2:0]  rdy, nb, bv, lb;

  assign bus0.word_valid = vld[0];
  assign bus1.word_valid = vld[1];
  assign bus2.word_valid = vld[2];
  assign bus0.word_data  = dat[0][7:0];
  assign bus1.word_data  = dat[1][3:0];
  assign bus2.word_data  = dat[2][0:0];
  assign rdy = {bus2.word_ready, bus1.word_ready, bus0.word_ready};
  assign nb  = {bus2.new_bit,    bus1.new_bit,    bus0.new_bit};
  assign bv  = {bus2.bit_valid,  bus1.bit_valid,  bus0.bit_valid};
  assign lb  = {bus2.last_bit,   bus1.last_bit,   bus0.last_bit};

  int chk = 0;
  int err = 0;

  // Model: per DUT, the bits still to appear on new_bit ({last, bit}); front = current cycle.
  logic [1:0]  mq  [3][$];
  logic [31:0] src [3][$];
  bit   [2:0]  acc;

  function automatic int wid(input int d);
    return (d == 0) ? 8 : (d == 1) ? 4 : 1;
  endfunction

  function automatic bit msb(input int d);
    return d != 1;
  endfunction

  function automatic bit idle(input int d);
    return d == 1;
  endfunction

  task automatic check(input string tag, input int d, input logic obs, input logic exp);
    chk++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s dut%0d: observed %b expected %b", tag, d, obs, exp);
    end
  endtask

  task automatic tick();
    logic er;
    #1;
    for (int d = 0; d < 3; d++) begin
      er = !rst && (mq[d].size() <= 1);
      check("word_ready", d, rdy[d], er);
      acc[d] = vld[d] && er;
    end
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        mq[d].delete();
      end else begin
        if (mq[d].size() > 0) void'(mq[d].pop_front());
        if (acc[d]) begin
          for (int i = 0; i < wid(d); i++) begin
            mq[d].push_back({(i == wid(d) - 1),
                             msb(d) ? dat[d][wid(d) - 1 - i] : dat[d][i]});
          end
        end
      end
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      if (mq[d].size() > 0) begin
        check("new_bit",   d, nb[d], mq[d][0][0]);
        check("bit_valid", d, bv[d], 1'b1);
        check("last_bit",  d, lb[d], mq[d][0][1]);
      end else begin
        check("new_bit",   d, nb[d], idle(d));
        check("bit_valid", d, bv[d], 1'b0);
        check("last_bit",  d, lb[d], 1'b0);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      for (int d = 0; d < 3; d++) begin
        vld[d] = (src[d].size() > 0);
        dat[d] = vld[d] ? src[d][0] : $urandom();
      end
      tick();
      for (int d = 0; d < 3; d++) begin
        if (acc[d]) void'(src[d].pop_front());
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) dat[d] = '0;
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(2);

    // Gapless pair on dut0, single LSB-first word on dut1, alternating stream on dut2
    src[0].push_back(32'hA5);
    src[0].push_back(32'h3C);
    src[1].push_back(32'h1);
    for (int i = 0; i < 6; i++) src[2].push_back(32'(i % 2 == 0));
    run(22);

    // Reset during the third bit of a word, with a new word waiting through the reset
    src[0].push_back(32'hC7);
    run(3);
    src[0].push_back(32'h96);
    src[1].push_back(32'hA);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(12);

    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 3; d++) begin
        if ($urandom_range(0, 3) == 0 && src[d].size() < 3) src[d].push_back($urandom());
      end
      rst = ($urandom_range(0, 63) == 0);
      run(1);
    end
    rst = 1'b0;
    run(20);

    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/word_serializer.md
# word_serializer

Parallel-to-serial front end for the serial sequence-detection path: accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on new_bit. It sits directly upstream of the 4-bit and 6-bit shift-register sequence detectors, whose new_bit input it drives. It supports gapless back-to-back words and drives a defined idle level between words.

## Interface
- WIDTH, 8, word width in bits; legal range 1..32
- MSB_FIRST, 1, 1 = emit word_data[WIDTH-1] first; 0 = emit word_data[0] first
- IDLE_BIT, 0, level driven on new_bit when no word is being shifted
- clk  input  1  clock; all logic on the rising edge
- rst  input  1  reset; synchronous, active-high
- word_valid  input  1  word_data holds a word to serialize
- word_data  input  WIDTH  word; sampled only on the handshake edge
- word_ready  output  1  block can accept a word this cycle
- new_bit  output  1  serial data to the detector; registered
- bit_valid  output  1  new_bit carries word data, not idle; registered
- last_bit  output  1  new_bit is the final bit of the current word; registered

## Operation
- Handshake: a word is accepted on any rising edge where word_valid && word_ready && !rst. word_data may change freely at all other times.
- States:
  - IDLE: no word loaded.
  - SHIFT: word in progress. Bit counter cnt runs 0..WIDTH-1.
- Transitions:
  - IDLE -> SHIFT on accept. Shift register loads word_data; cnt <= 0.
  - SHIFT, cnt < WIDTH-1: shift by one bit; cnt++.
  - SHIFT, cnt == WIDTH-1, accept: reload the shift register; cnt <= 0; stay in SHIFT (gapless).
  - SHIFT, cnt == WIDTH-1, no accept: go to IDLE.
- word_ready is combinational. It is 0 while rst is high. Otherwise it is 1 when (state == IDLE) || (cnt == WIDTH-1).
- new_bit:
  - In SHIFT it is the current head bit: the MSB end if MSB_FIRST, else the LSB end.
  - In IDLE it is IDLE_BIT.
- bit_valid = (state == SHIFT).
- last_bit = (state == SHIFT) && (cnt == WIDTH-1).
- WIDTH == 1: every SHIFT cycle is a last cycle, so word_ready stays high throughout.
- word_valid held high while word_ready is low: no effect. The word is held by the source (standard valid/ready; the source must not drop word_valid before acceptance).

## Timing
- Reset values: state IDLE, cnt 0, shift register 0, new_bit = IDLE_BIT, bit_valid 0, last_bit 0. word_ready is 0 during the rst cycle and 1 on the first cycle after.
- Latency:
  - Word accepted at edge N: first bit appears on new_bit in cycle N+1.
  - Bit k appears in cycle N+1+k.
  - last_bit is high in cycle N+WIDTH.
- Gapless streaming: a word accepted on the edge that ends its predecessor's last-bit cycle puts its first bit in the very next cycle. There are no idle bits between the two words.
- Throughput: one word per WIDTH cycles maximum.
- Reset mid-word: the word is discarded. In the next cycle new_bit = IDLE_BIT and bit_valid = 0. Nothing is resumed.
- rst and word_valid in the same cycle: rst wins and the word is not accepted (word_ready is 0).
- Downstream detectors sample new_bit every cycle regardless of bit_valid. IDLE_BIT is therefore chosen per instance so that idle gaps cannot complete a target pattern.

## Structure
- Shared package serializer_pkg holds:
  - typedef enum logic {IDLE, SHIFT} ser_state_t
  - a localparam for the maximum supported WIDTH (32)
- Counter width: $clog2(WIDTH) bits, with a minimum of 1.
- No sub-module is needed. The FSM, counter and shift register are one always_ff block plus combinational word_ready.
- Top-level integration pairs one word_serializer with one detector via new_bit.

## Test plan
- Basic word: WIDTH=6, MSB_FIRST=1. Accept 6'b110011 at edge N -> new_bit = 1,1,0,0,1,1 in cycles N+1..N+6; bit_valid high for those six cycles; last_bit only in N+6. The downstream 6-bit detector asserts detected in cycle N+7.
- Gapless: WIDTH=8. Hold word_valid with 8'hA5 then 8'h3C -> 16 consecutive valid bits 10100101_00111100. word_ready is high only in IDLE and in the two last-bit cycles; no IDLE_BIT appears between the words.
- LSB-first: WIDTH=4, MSB_FIRST=0. Word 4'b0001 -> new_bit = 1,0,0,0. Idle afterwards shows IDLE_BIT with bit_valid = 0.
- Reset mid-word: WIDTH=8, rst asserted during the 3rd bit -> next cycle new_bit = IDLE_BIT, bit_valid = 0, word_ready = 1. A new word accepted immediately afterwards starts from its first bit.
- Backpressure/boundary: WIDTH=1 with word_valid held high and an alternating data pattern -> one bit per cycle, last_bit high every cycle. Separately, with WIDTH=8, word_valid asserted mid-word -> not accepted until the last-bit cycle.
